led_matrix_status_scanner: RTL and testbench
============================================

# led_matrix_status_scanner

Time-multiplexed driver for the 7-row LED matrix that shows the irrigation status glyph. It scans NUM_COLS columns one at a time and drives each column's row pattern from an internal glyph table. The inputs are latched only at frame boundaries, so the image never tears, and an optional blink mode applies. It sits between the irrigation controller's 2-bit status output and the matrix pins, and replaces the per-column combinational decoders.

## Interface
- NUM_COLS, 5, number of scanned columns (1..8); columns 5 and above are always blank
- SCAN_DIV, 5000, clock cycles each column stays active (>=1)
- BLINK_FRAMES, 25, frames per blink half-period (>=1)
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- irrigation_status  input  2  0 idle, 1 irrigating, 2 tank full, 3 fault
- blink_en  input  1  request blinking of the glyph
- columns  output  NUM_COLS  one-hot active-high column select
- rows_values  output  7  active-high row data; bit 0 is the top row
- frame_start  output  1  one-cycle pulse when column 0 becomes active

## Operation
- State registers:
  - active flag
  - col_idx, width max(1,clog2(NUM_COLS))
  - prescaler, width max(1,clog2(SCAN_DIV))
  - st_lat (2 bits) and blk_lat (1 bit)
  - frame counter, width max(1,clog2(BLINK_FRAMES))
  - phase (1 = visible)
- Reset values: active=0, col_idx=0, prescaler=0, st_lat=0, blk_lat=0, frame counter=0, phase=1.
- While active=0, all outputs are 0: columns=0, rows_values=0, frame_start=0.
- First edge after reset with reset low:
  - active<=1, col_idx<=0, prescaler<=0.
  - This is a frame boundary: the status and blink inputs are latched.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and col_idx advances. col_idx wraps from NUM_COLS-1 to 0.
- Frame boundary is the edge on which col_idx becomes 0 (wrap or activation). On that edge:
  - st_lat <= irrigation_status.
  - blk_lat <= blink_en | (irrigation_status==3); fault always blinks.
  - If the new blk_lat is 0: frame counter <= 0 and phase <= 1.
  - Otherwise, if the frame counter equals BLINK_FRAMES-1: counter <= 0 and phase toggles.
  - Otherwise the counter increments.
- Input changes between frame boundaries have no visible effect.
- Outputs are combinational decodes of the registers:
  - columns[i] = active & (col_idx==i).
  - rows_values = (active & phase) ? glyph(st_lat, col_idx) : 0.
  - frame_start = active & (col_idx==0) & (prescaler==0) & the previous cycle was a boundary edge. In practice this is a registered pulse set on the boundary edge.
- Glyph table, columns 0..4, in hex:
  - status 0: 00,77,49,77,00
  - status 1: 00,76,49,76,00
  - status 2: 3E,3E,3E,3E,3E
  - status 3: 63,14,08,14,63
  - col_idx >= 5 gives 00.
- While blanked (phase=0), columns keep scanning; only rows are forced to 0.
- Reset asserted mid-frame returns every register to its reset value on that edge. No partial column or frame completes.

## Timing
- Column period is SCAN_DIV cycles; frame period is NUM_COLS*SCAN_DIV cycles.
- Blink half-period is BLINK_FRAMES frames.
- The first column is visible 1 cycle after reset deasserts, with the status sampled on that edge.
- A status change becomes visible on the first frame boundary after it, at worst NUM_COLS*SCAN_DIV cycles later.
- frame_start is high for exactly 1 cycle per frame, aligned with the first cycle of column 0.
- SCAN_DIV=1: the column advances every cycle.
- NUM_COLS=1: every column-advance edge is a frame boundary.

## Test plan
Bench parameters: NUM_COLS=5, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset with status=0, blink_en=0, then release:
  - During reset, columns=0 and rows_values=0.
  - Next cycle: columns=5'b00001, rows_values=7'h00, frame_start=1.
  - Columns then step 00010, 00100, ... every 4 cycles, with rows 77, 49, 77, 00.
  - frame_start repeats every 20 cycles.
- Status changes 0->2 mid-frame at column 2:
  - Columns 2..4 still show 49, 77, 00.
  - From the next frame_start, all five columns show 3E.
- Status=3, blink_en=0:
  - Two frames show the glyph 63, 14, 08, 14, 63.
  - The next two frames show rows_values=0 while columns keep scanning.
  - The pattern then repeats.
- blink_en=1 with status=1, then blink_en deasserted during a blanked frame:
  - The display stays blank until the next boundary.
  - It then shows 00, 76, 49, 76, 00 continuously.
- Reset asserted at column 3, prescaler 2:
  - On the same edge, columns=0 and rows_values=0.
  - After release, the scan restarts at column 0 with frame_start=1.
- NUM_COLS=7, SCAN_DIV=1:
  - The column advances every cycle.
  - Columns 5 and 6 drive rows_values=0.
  - frame_start comes every 7 cycles.

Source files
------------

// File: rtl/led_matrix_status_scanner_if.sv
// Bus between the irrigation controller and the LED matrix scanner.
//   irrigation_status : 2-bit status code (0 idle, 1 irrigating, 2 tank full, 3 fault)
//   blink_en          : request blinking of the glyph
//   columns           : one-hot active-high column select, NUM_COLS wide
//   rows_values       : active-high row data, bit 0 is the top row
//   frame_start       : one-cycle pulse on the first cycle of column 0
// master drives the status inputs and observes the matrix pins; slave is the scanner.
interface led_matrix_status_scanner_if #(
  parameter int NUM_COLS = 5
);
  logic [1:0]          irrigation_status;
  logic                blink_en;
  logic [NUM_COLS-1:0] columns;
  logic [6:0]          rows_values;
  logic                frame_start;

  modport master (
    output irrigation_status, blink_en,
    input  columns, rows_values, frame_start
  );

  modport slave (
    input  irrigation_status, blink_en,
    output columns, rows_values, frame_start
  );
endinterface

// File: rtl/led_matrix_status_scanner.sv
// Time-multiplexed driver for the 7-row irrigation status LED matrix.
// Scans NUM_COLS columns, each held for SCAN_DIV cycles, and drives the row
// pattern of the latched status glyph. Status and blink request are latched
// only at frame boundaries so the image never tears; blinking (requested, or
// forced by a fault) blanks the rows for BLINK_FRAMES frames at a time.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of led_matrix_status_scanner_if (status in, matrix pins out)
module led_matrix_status_scanner #(
  parameter int NUM_COLS     = 5,
  parameter int SCAN_DIV     = 5000,
  parameter int BLINK_FRAMES = 25
) (
  input logic                        clk,
  input logic                        reset,
  led_matrix_status_scanner_if.slave bus
);

  localparam int CW = (NUM_COLS > 1)     ? $clog2(NUM_COLS)     : 1;
  localparam int PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          active;
  logic [CW-1:0] col_idx;
  logic [PW-1:0] prescaler;
  logic [1:0]    st_lat;
  logic          blk_lat;
  logic [FW-1:0] frm_cnt;
  logic          phase;
  logic          fs_q;

  logic          col_tick;
  logic          boundary;
  logic          blk_nxt;

  function automatic logic [6:0] glyph(input logic [1:0] st, input logic [CW-1:0] col);
    logic [6:0] g;
    g = 7'h00;
    case (st)
      2'd0: case (int'(col))
              1, 3:    g = 7'h77;
              2:       g = 7'h49;
              default: g = 7'h00;
            endcase
      2'd1: case (int'(col))
              1, 3:    g = 7'h76;
              2:       g = 7'h49;
              default: g = 7'h00;
            endcase
      2'd2: if (int'(col) < 5) g = 7'h3E;
      default: case (int'(col))
              0, 4:    g = 7'h63;
              1, 3:    g = 7'h14;
              2:       g = 7'h08;
              default: g = 7'h00;
            endcase
    endcase
    return g;
  endfunction

  // State register: idle until the first edge out of reset, then scanning.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_SCAN;
      S_SCAN:  state_nxt = S_SCAN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Activation counts as a frame boundary so the first frame shows fresh inputs.
  always_comb begin
    col_tick = (prescaler == PRE_LAST);
    boundary = !active || (col_tick && (col_idx == COL_LAST));
    blk_nxt  = bus.blink_en | (bus.irrigation_status == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_idx   <= '0;
      prescaler <= '0;
      st_lat    <= 2'd0;
      blk_lat   <= 1'b0;
      frm_cnt   <= '0;
      phase     <= 1'b1;
      fs_q      <= 1'b0;
    end else begin
      if (!active) begin
        col_idx   <= '0;
        prescaler <= '0;
      end else if (col_tick) begin
        prescaler <= '0;
        col_idx   <= (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      fs_q <= boundary;

      if (boundary) begin
        st_lat  <= bus.irrigation_status;
        blk_lat <= blk_nxt;
        if (!blk_nxt) begin
          frm_cnt <= '0;
          phase   <= 1'b1;
        end else if (frm_cnt == FRM_LAST) begin
          frm_cnt <= '0;
          phase   <= ~phase;
        end else begin
          frm_cnt <= frm_cnt + FW'(1);
        end
      end
    end
  end

  // Outputs decode straight from the registers. Phase is held at 1 whenever
  // blinking is off; the OR with ~blk_lat keeps that invariant explicit.
  always_comb begin
    active      = (state == S_SCAN);
    bus.columns = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      bus.columns[i] = active && (int'(col_idx) == i);
    end
    bus.rows_values = (active && (phase || !blk_lat)) ? glyph(st_lat, col_idx) : 7'h00;
    bus.frame_start = active && fs_q;
  end

endmodule

// File: tb/tb_led_matrix_status_scanner.sv
module tb_led_matrix_status_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, rb;

  led_matrix_status_scanner_if #(.NUM_COLS(5)) ifa ();
  led_matrix_status_scanner_if #(.NUM_COLS(7)) ifb ();

  led_matrix_status_scanner #(.NUM_COLS(5), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut_a (
    .clk   (clk),
    .reset (ra),
    .bus   (ifa)
  );

  led_matrix_status_scanner #(.NUM_COLS(7), .SCAN_DIV(1), .BLINK_FRAMES(2)) dut_b (
    .clk   (clk),
    .reset (rb),
    .bus   (ifb)
  );

  typedef struct {
    bit       active;
    int       col;
    int       pre;
    bit [1:0] st;
    bit       blk;
    int       cnt;
    bit       phase;
    bit       fs;
  } mstate_t;

  mstate_t     ma, mb;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit          a_on, b_on;
  int          n_cmp, n_bad;

  function automatic logic [6:0] gl(input bit [1:0] st, input int col);
    logic [6:0] t0 [5];
    logic [6:0] t1 [5];
    logic [6:0] t3 [5];
    t0 = '{7'h00, 7'h77, 7'h49, 7'h77, 7'h00};
    t1 = '{7'h00, 7'h76, 7'h49, 7'h76, 7'h00};
    t3 = '{7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
    if (col >= 5) return 7'h00;
    case (st)
      2'd0:    return t0[col];
      2'd1:    return t1[col];
      2'd2:    return 7'h3E;
      default: return t3[col];
    endcase
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input bit rst, input bit [1:0] status,
                                    input bit ben, input int nc, input int sd, input int bf);
    mstate_t n;
    bit bnd;
    n = s;
    if (rst) begin
      n.active = 0; n.col = 0; n.pre = 0; n.st = 0; n.blk = 0; n.cnt = 0; n.phase = 1; n.fs = 0;
      return n;
    end
    bnd  = 0;
    n.fs = 0;
    if (!s.active) begin
      n.active = 1; n.col = 0; n.pre = 0; bnd = 1;
    end else if (s.pre == sd - 1) begin
      n.pre = 0;
      if (s.col == nc - 1) begin n.col = 0; bnd = 1; end
      else n.col = s.col + 1;
    end else begin
      n.pre = s.pre + 1;
    end
    if (bnd) begin
      n.fs  = 1;
      n.st  = status;
      n.blk = ben | (status == 2'd3);
      if (!n.blk) begin n.cnt = 0; n.phase = 1; end
      else if (s.cnt == bf - 1) begin n.cnt = 0; n.phase = ~s.phase; end
      else n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  function automatic logic [15:0] mexp(input mstate_t s);
    logic [7:0] c;
    logic [6:0] r;
    c = 8'h00;
    r = 7'h00;
    if (s.active) begin
      c = 8'(1) << s.col;
      if (s.phase) r = gl(s.st, s.col);
    end
    return {c, r, s.active & s.fs};
  endfunction

  function automatic logic [15:0] act_a();
    return {3'b000, ifa.columns, ifa.rows_values, ifa.frame_start};
  endfunction

  function automatic logic [15:0] act_b();
    return {1'b0, ifb.columns, ifb.rows_values, ifb.frame_start};
  endfunction

  function automatic int col_of(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    if (a_on) begin
      ma = mstep(ma, ra, ifa.irrigation_status, ifa.blink_en, 5, 4, 2);
      qa.push_back(mexp(ma));
    end
    if (b_on) begin
      mb = mstep(mb, rb, ifb.irrigation_status, ifb.blink_en, 7, 1, 2);
      qb.push_back(mexp(mb));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    logic [6:0]  rtab [5];
    int last_fs, n_fs, c;
    rtab = '{7'h00, 7'h77, 7'h49, 7'h77, 7'h00};
    ra = 1'b1;
    ifa.irrigation_status = 2'd0;
    ifa.blink_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL reset_hold: got %h expected %h", act_a(), e); end
      n_cmp++;
      if ({ifa.columns, ifa.rows_values} !== 12'h000) begin
        n_bad++; $display("FAIL reset_zero: got cols=%b rows=%h expected 0", ifa.columns, ifa.rows_values);
      end
    end
    ra = 1'b0;
    tick();
    e = qa.pop_front();
    n_cmp++;
    if (act_a() !== e) begin n_bad++; $display("FAIL release_sb: got %h expected %h", act_a(), e); end
    n_cmp++;
    if ({ifa.columns, ifa.rows_values, ifa.frame_start} !== {5'b00001, 7'h00, 1'b1}) begin
      n_bad++; $display("FAIL release_first: got cols=%b rows=%h fs=%b expected 00001/00/1",
                        ifa.columns, ifa.rows_values, ifa.frame_start);
    end
    last_fs = 0;
    n_fs = 0;
    for (int k = 1; k < 45; k++) begin
      tick();
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL scan0 k=%0d: got %h expected %h", k, act_a(), e); end
      if (k % 4 == 0) begin
        c = (k / 4) % 5;
        n_cmp++;
        if ({ifa.columns, ifa.rows_values} !== {5'(1 << c), rtab[c]}) begin
          n_bad++; $display("FAIL scan0_col k=%0d: got cols=%b rows=%h expected col %0d rows %h",
                            k, ifa.columns, ifa.rows_values, c, rtab[c]);
        end
      end
      if (ifa.frame_start === 1'b1) begin
        n_fs++;
        n_cmp++;
        if (k - last_fs != 20) begin n_bad++; $display("FAIL fs_period: got %0d expected 20", k - last_fs); end
        last_fs = k;
      end
    end
    n_cmp++;
    if (n_fs != 2) begin n_bad++; $display("FAIL fs_count: got %0d expected 2", n_fs); end
  endtask

  task automatic test_status_change();
    logic [15:0] e;
    bit changed, seen_fs;
    changed = 0;
    seen_fs = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL status_chg k=%0d: got %h expected %h", k, act_a(), e); end
      if (changed && ifa.frame_start === 1'b1) seen_fs = 1;
      if (seen_fs) begin
        n_cmp++;
        if (ifa.rows_values !== 7'h3E) begin
          n_bad++; $display("FAIL tank_full_rows k=%0d: got %h expected 3e", k, ifa.rows_values);
        end
      end else if (changed) begin
        n_cmp++;
        if (ifa.rows_values !== gl(2'd0, col_of(8'(ifa.columns)))) begin
          n_bad++; $display("FAIL no_tear k=%0d: got %h expected %h", k, ifa.rows_values,
                            gl(2'd0, col_of(8'(ifa.columns))));
        end
      end
      if (!changed && ma.col == 2 && ma.pre == 0) begin
        ifa.irrigation_status = 2'd2;
        changed = 1;
      end
    end
    n_cmp++;
    if (!seen_fs) begin n_bad++; $display("FAIL status_chg_timeout: got no frame_start expected one"); end
  endtask

  task automatic test_fault_blink();
    logic [15:0] e;
    logic [6:0]  vis, exp_vis;
    int nf, blank_scan;
    exp_vis = 7'b0011001;
    vis = '0;
    nf = 0;
    blank_scan = 0;
    ifa.irrigation_status = 2'd3;
    ifa.blink_en = 1'b0;
    for (int k = 0; k < 145; k++) begin
      tick();
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL fault k=%0d: got %h expected %h", k, act_a(), e); end
      if (ifa.columns != 0 && ifa.rows_values == 7'h00 && ifa.columns[0] !== 1'b1 && ifa.columns[4] !== 1'b1)
        blank_scan++;
      if (ifa.frame_start === 1'b1 && nf < 7) begin
        vis[nf] = (ifa.rows_values != 7'h00);
        nf++;
      end
    end
    n_cmp++;
    if (nf != 7 || vis !== exp_vis) begin
      n_bad++; $display("FAIL fault_pattern: got frames=%0d vis=%b expected 7 vis=%b", nf, vis, exp_vis);
    end
    n_cmp++;
    if (blank_scan == 0) begin n_bad++; $display("FAIL fault_scan_blank: got 0 blank scanned cycles expected >0"); end
  endtask

  task automatic test_blink_deassert();
    logic [15:0] e;
    bit dropped, shown;
    int k, after;
    dropped = 0;
    shown = 0;
    after = 0;
    k = 0;
    ifa.irrigation_status = 2'd1;
    ifa.blink_en = 1'b1;
    while (k < 300 && after < 40) begin
      tick();
      k++;
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL blink k=%0d: got %h expected %h", k, act_a(), e); end
      if (dropped && ifa.frame_start === 1'b1) shown = 1;
      if (shown) begin
        after++;
        n_cmp++;
        if (ifa.rows_values !== gl(2'd1, col_of(8'(ifa.columns)))) begin
          n_bad++; $display("FAIL blink_off_show k=%0d: got %h expected %h", k, ifa.rows_values,
                            gl(2'd1, col_of(8'(ifa.columns))));
        end
      end else if (dropped) begin
        n_cmp++;
        if (ifa.rows_values !== 7'h00 || ifa.columns == 0) begin
          n_bad++; $display("FAIL blink_off_blank k=%0d: got cols=%b rows=%h expected scanning with rows 00",
                            k, ifa.columns, ifa.rows_values);
        end
      end
      if (!dropped && ma.phase == 0 && ma.col == 1) begin
        ifa.blink_en = 1'b0;
        dropped = 1;
      end
    end
    n_cmp++;
    if (!shown || after < 40) begin n_bad++; $display("FAIL blink_timeout: got shown=%0d after=%0d expected 1/40", shown, after); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    bit hit;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL pre_mid k=%0d: got %h expected %h", k, act_a(), e); end
      if (ma.col == 3 && ma.pre == 2) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_bad++; $display("FAIL mid_timeout: got no col3/pre2 expected one"); end
    ra = 1'b1;
    tick();
    e = qa.pop_front();
    n_cmp++;
    if ({ifa.columns, ifa.rows_values, ifa.frame_start} !== 13'h0 || act_a() !== e) begin
      n_bad++; $display("FAIL mid_reset: got %h expected %h", act_a(), e);
    end
    ra = 1'b0;
    tick();
    e = qa.pop_front();
    n_cmp++;
    if ({ifa.columns, ifa.rows_values, ifa.frame_start} !== {5'b00001, 7'h00, 1'b1} || act_a() !== e) begin
      n_bad++; $display("FAIL mid_restart: got %h expected %h", act_a(), e);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      e = qa.pop_front();
      n_cmp++;
      if (act_a() !== e) begin n_bad++; $display("FAIL post_mid k=%0d: got %h expected %h", k, act_a(), e); end
    end
  endtask

  task automatic test_ncols7();
    logic [15:0] e;
    logic [14:0] want;
    int c;
    a_on = 0;
    b_on = 1;
    qb.delete();
    rb = 1'b1;
    ifb.irrigation_status = 2'd2;
    ifb.blink_en = 1'b0;
    tick();
    e = qb.pop_front();
    n_cmp++;
    if (act_b() !== e) begin n_bad++; $display("FAIL n7_reset: got %h expected %h", act_b(), e); end
    rb = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      e = qb.pop_front();
      c = k % 7;
      want = {7'(1 << c), (c < 5) ? 7'h3E : 7'h00, (c == 0)};
      n_cmp++;
      if (act_b() !== e) begin n_bad++; $display("FAIL n7_sb k=%0d: got %h expected %h", k, act_b(), e); end
      n_cmp++;
      if ({ifb.columns, ifb.rows_values, ifb.frame_start} !== want) begin
        n_bad++; $display("FAIL n7_scan k=%0d: got %h expected %h", k,
                          {ifb.columns, ifb.rows_values, ifb.frame_start}, want);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    a_on = 1;
    b_on = 0;
    ra = 1'b1;
    rb = 1'b1;
    ifa.irrigation_status = 2'd0;
    ifa.blink_en = 1'b0;
    ifb.irrigation_status = 2'd0;
    ifb.blink_en = 1'b0;
    ma = '{active: 0, col: 0, pre: 0, st: 0, blk: 0, cnt: 0, phase: 1, fs: 0};
    mb = ma;
    test_reset();
    test_status_change();
    test_fault_blink();
    test_blink_deassert();
    test_reset_mid();
    test_ncols7();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
